// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the I/D memory arbiter.
package mem_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;

  // Never returns zero, so the counter has a legal width even with the watchdog off.
  function automatic int tmo_width(input int timeout_cycles);
    return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, LSU and memory signal bundle; slave = arbiter view, master = core/memory view.
interface mem_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int MASK_SIZE = DATA_WIDTH / 8;

  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_err;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [MASK_SIZE-1:0]  d_mask;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_err;

  logic                  m_req;
  logic                  m_we;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [MASK_SIZE-1:0]  m_mask;
  logic                  m_gnt;
  logic                  m_rvalid;
  logic [DATA_WIDTH-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_mask, m_gnt, m_rvalid, m_rdata,
    output i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
           m_req, m_we, m_addr, m_wdata, m_mask
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_mask, m_gnt, m_rvalid, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
           m_req, m_we, m_addr, m_wdata, m_mask
  );

endinterface

// File: rtl/arb_watchdog.sv
// Busy-cycle counter: expired_o rises when the count reaches TIMEOUT_CYCLES-1; constant 0 when TIMEOUT_CYCLES=0.
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int CW = tmo_width(TIMEOUT_CYCLES);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_in;
      assign unused_in = clk ^ rst ^ clear_i ^ enable_i;
      assign expired_o = 1'b0;
    end else begin : g_on
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      assign expired_o = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

      always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
          cnt_d = '0;
        end else if (enable_i && !expired_o) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory between fetch (I) and LSU (D), with response watchdog.
// Fixed priority D over I by default; define MEM_ARB_RR_EN for round-robin between simultaneous requests.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic      clk,
  input logic      rst,
  mem_arb_if.slave bus
);
  localparam int MASK_SIZE = DATA_WIDTH / 8;

  arb_state_t state_q;
  arb_owner_t owner_q;
  logic       lock_q;
  logic       we_q;
`ifdef MEM_ARB_RR_EN
  arb_owner_t rr_q;
`endif

  arb_owner_t            sel;
  logic                  idle;
  logic                  busy;
  logic                  mreq;
  logic                  sel_d;
  logic                  wd_exp;
  logic                  rsp_vld;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] rsp_data;

  // A stalled request keeps its selection so m_* stay stable until m_gnt.
  always_comb begin
    sel = OWN_D;
    if (lock_q) begin
      sel = owner_q;
    end else if (bus.i_req && !bus.d_req) begin
      sel = OWN_I;
`ifdef MEM_ARB_RR_EN
    end else if (bus.i_req && bus.d_req) begin
      sel = rr_q;
`endif
    end
  end

  assign idle  = (state_q == ARB_IDLE) && !rst;
  assign busy  = (state_q == ARB_BUSY) && !rst;
  assign sel_d = (sel == OWN_D);
  assign mreq  = idle && (sel_d ? bus.d_req : bus.i_req);

  assign bus.m_req   = mreq;
  assign bus.m_we    = mreq && sel_d && bus.d_we;
  assign bus.m_addr  = !mreq ? '0 : (sel_d ? bus.d_addr : bus.i_addr);
  assign bus.m_wdata = (mreq && sel_d) ? bus.d_wdata : '0;
  assign bus.m_mask  = (mreq && sel_d) ? bus.d_mask : MASK_SIZE'(0);
  assign bus.d_gnt   = mreq && sel_d && bus.m_gnt;
  assign bus.i_gnt   = mreq && !sel_d && bus.m_gnt;

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q == ARB_IDLE),
    .enable_i (busy),
    .expired_o(wd_exp)
  );

  // A real memory answer wins over a same-cycle timeout.
  assign rsp_vld  = busy && (bus.m_rvalid || wd_exp);
  assign rsp_err  = busy && !bus.m_rvalid && wd_exp;
  assign rsp_data = (busy && bus.m_rvalid && !we_q) ? bus.m_rdata : '0;

  assign bus.i_rvalid = rsp_vld && (owner_q == OWN_I);
  assign bus.i_err    = rsp_err && (owner_q == OWN_I);
  assign bus.i_rdata  = (owner_q == OWN_I) ? rsp_data : '0;
  assign bus.d_rvalid = rsp_vld && (owner_q == OWN_D);
  assign bus.d_err    = rsp_err && (owner_q == OWN_D);
  assign bus.d_rdata  = (owner_q == OWN_D) ? rsp_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_D;
      lock_q  <= 1'b0;
      we_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_q    <= OWN_D;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (mreq) begin
            owner_q <= sel;
            we_q    <= sel_d && bus.d_we;
            if (bus.m_gnt) begin
              state_q <= ARB_BUSY;
              lock_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
              rr_q    <= sel_d ? OWN_I : OWN_D;
`endif
            end else begin
              lock_q <= 1'b1;
            end
          end
        end
        ARB_BUSY: begin
          if (rsp_vld) begin
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench: stimulus pushes expected grant/response events, a negedge monitor checks them.
module tb_mem_arbiter;

  typedef struct packed {
    int          cyc;
    bit          rsp;
    bit          port_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
    logic        err;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];
  ev_t  mon_act;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus();

  mem_arbiter #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic compare_ev(input ev_t act);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got cyc=%0d rsp=%0d port_d=%0d, required no event",
               act.cyc, act.rsp, act.port_d);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got cyc=%0d rsp=%0d d=%0d we=%0d addr=%h wdata=%h mask=%h rdata=%h err=%0d, required cyc=%0d rsp=%0d d=%0d we=%0d addr=%h wdata=%h mask=%h rdata=%h err=%0d",
                 e.rsp ? "response" : "grant",
                 act.cyc, act.rsp, act.port_d, act.we, act.addr, act.wdata, act.mask, act.rdata, act.err,
                 e.cyc, e.rsp, e.port_d, e.we, e.addr, e.wdata, e.mask, e.rdata, e.err);
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.i_gnt || bus.d_gnt) begin
      mon_act        = '0;
      mon_act.cyc    = cyc;
      mon_act.port_d = bus.d_gnt;
      mon_act.we     = bus.m_we;
      mon_act.addr   = bus.m_addr;
      mon_act.wdata  = bus.m_wdata;
      mon_act.mask   = bus.m_mask;
      compare_ev(mon_act);
      if (bus.i_gnt && bus.d_gnt) chk("dual_gnt", 64'(1), 64'(0));
    end
    if (bus.i_rvalid || bus.d_rvalid) begin
      mon_act        = '0;
      mon_act.cyc    = cyc;
      mon_act.rsp    = 1'b1;
      mon_act.port_d = bus.d_rvalid;
      mon_act.rdata  = bus.i_rdata | bus.d_rdata;
      mon_act.err    = bus.i_err | bus.d_err;
      compare_ev(mon_act);
      if (bus.i_rvalid && bus.d_rvalid) chk("dual_rvalid", 64'(1), 64'(0));
    end
    if (!bus.i_rvalid) chk("i_idle_data", {31'b0, bus.i_err, bus.i_rdata}, 64'(0));
    if (!bus.d_rvalid) chk("d_idle_data", {31'b0, bus.d_err, bus.d_rdata}, 64'(0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_mask = '0;
    bus.m_gnt = 0; bus.m_rvalid = 0; bus.m_rdata = '0;
  endtask

  task automatic push_gnt(input int c, input bit d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask);
    ev_t e;
    e = '0; e.cyc = c; e.port_d = d; e.we = we; e.addr = addr; e.wdata = wdata; e.mask = mask;
    exp_q.push_back(e);
  endtask

  task automatic push_rsp(input int c, input bit d, input logic [31:0] rdata, input bit err);
    ev_t e;
    e = '0; e.cyc = c; e.rsp = 1'b1; e.port_d = d; e.rdata = rdata; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic chk_quiet(input string nm);
    @(negedge clk);
    chk(nm, 64'(|{bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_mask, bus.i_gnt, bus.d_gnt,
                  bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata, bus.i_err, bus.d_err}), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no end of stimulus, required finish");
    $fatal(1);
  end

  initial begin
    int c0;
    bit pd;
    clear_inputs();
    rst = 1;
    bus.i_req = 1; bus.i_addr = 32'h10; bus.m_gnt = 1;
    tick();
    tick();
    chk_quiet("reset_outputs");
    clear_inputs();
    rst = 0;
    tick();

    // 1: both request, D wins, I follows after D response
    c0 = cyc;
    bus.i_req = 1; bus.i_addr = 32'h100;
    bus.d_req = 1; bus.d_addr = 32'h200; bus.m_gnt = 1;
    push_gnt(c0, 1, 0, 32'h200, 0, 0);
    push_rsp(c0 + 2, 1, 32'hDEADBEEF, 0);
    push_gnt(c0 + 3, 0, 0, 32'h100, 0, 0);
    push_rsp(c0 + 5, 0, 32'h11112222, 0);
    tick(); bus.d_req = 0;
    tick(); bus.m_rvalid = 1; bus.m_rdata = 32'hDEADBEEF;
    tick(); bus.m_rvalid = 0;
    tick(); bus.i_req = 0;
    tick(); bus.m_rvalid = 1; bus.m_rdata = 32'h11112222;
    tick(); clear_inputs();
    tick();

    // 2: stalled I request stays locked against a later D request
    c0 = cyc;
    bus.i_req = 1; bus.i_addr = 32'h300; bus.m_gnt = 0;
    push_gnt(c0 + 3, 0, 0, 32'h300, 0, 0);
    push_rsp(c0 + 4, 0, 32'hCAFEF00D, 0);
    push_gnt(c0 + 5, 1, 0, 32'h400, 0, 0);
    push_rsp(c0 + 7, 1, 32'h00005555, 0);
    @(negedge clk); chk("stall_addr_c0", 64'(bus.m_addr), 64'h300);
    tick(); bus.d_req = 1; bus.d_addr = 32'h400;
    @(negedge clk); chk("stall_addr_c1", 64'(bus.m_addr), 64'h300);
    tick();
    @(negedge clk); chk("stall_addr_c2", 64'(bus.m_addr), 64'h300);
    tick(); bus.m_gnt = 1;
    @(negedge clk); chk("stall_addr_c3", 64'(bus.m_addr), 64'h300);
    tick(); bus.i_req = 0; bus.m_rvalid = 1; bus.m_rdata = 32'hCAFEF00D;
    tick(); bus.m_rvalid = 0;
    tick(); bus.d_req = 0;
    tick(); bus.m_rvalid = 1; bus.m_rdata = 32'h00005555;
    tick(); clear_inputs();
    tick();

    // 3: store passes fields through, ack returns zero data
    c0 = cyc;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h104; bus.d_mask = 4'b0100;
    bus.d_wdata = 32'h00AB0000; bus.m_gnt = 1;
    push_gnt(c0, 1, 1, 32'h104, 32'h00AB0000, 4'b0100);
    push_rsp(c0 + 1, 1, 32'h0, 0);
    tick(); bus.d_req = 0; bus.d_we = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h12345678;
    tick(); clear_inputs();
    tick();

    // 4: watchdog fires 8 cycles after grant, late answer dropped
    c0 = cyc;
    bus.d_req = 1; bus.d_addr = 32'h500; bus.m_gnt = 1;
    push_gnt(c0, 1, 0, 32'h500, 0, 0);
    push_rsp(c0 + 8, 1, 32'h0, 1);
    tick(); bus.d_req = 0;
    for (int k = 0; k < 7; k++) tick();
    tick(); bus.m_rvalid = 1; bus.m_rdata = 32'h00000077;
    tick(); clear_inputs();
    tick();

    // 5: reset while busy, stale answer dropped, fresh request served
    c0 = cyc;
    bus.i_req = 1; bus.i_addr = 32'h600; bus.m_gnt = 1;
    push_gnt(c0, 0, 0, 32'h600, 0, 0);
    tick(); bus.i_req = 0;
    tick(); rst = 1; bus.i_req = 1; bus.m_rvalid = 1; bus.m_rdata = 32'h99;
    chk_quiet("reset_mid_txn");
    tick(); rst = 0; bus.i_req = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h99;
    tick(); bus.m_rvalid = 0; bus.i_req = 1; bus.i_addr = 32'h700;
    push_gnt(cyc, 0, 0, 32'h700, 0, 0);
    push_rsp(cyc + 1, 0, 32'h0000ABCD, 0);
    tick(); bus.i_req = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h0000ABCD;
    tick(); clear_inputs();
    tick();

    // 6: both hold requests continuously
    bus.i_req = 1; bus.i_addr = 32'h800;
    bus.d_req = 1; bus.d_addr = 32'h900; bus.m_gnt = 1;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      pd = (k % 2 == 0);
`else
      pd = 1'b1;
`endif
      bus.m_rvalid = 0;
      push_gnt(cyc, pd, 0, pd ? 32'h900 : 32'h800, 0, 0);
      push_rsp(cyc + 1, pd, 32'h1000 + k, 0);
      tick(); bus.m_rvalid = 1; bus.m_rdata = 32'h1000 + k;
      tick();
    end
    clear_inputs();
    tick();
    tick();

    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
